// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM bridge: level-held load/store request and ready/read_data response.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Bridges one 32-bit MEM-stage load/store into two 16-bit SRAM accesses, low half first,
// holding ready low (pipeline freeze) until the word is done.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  inout  wire  [15:0]      SRAM_DQ,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] data;
  logic [31:0] rd_data;

  logic        req;
  logic        last;
  logic        accept;
  logic        cap_lo;
  logic        cap_hi;
  logic        ready_c;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic [16:0] word_in;

  assign req     = bus.wr_en | bus.rd_en;
  assign last    = (cnt == LAST_CNT);
  // Modulo-2^32 offset; the byte-in-word bits fall away with the shift.
  assign word_in = 17'((bus.address - BASE) >> 2);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    ready_c   = 1'b0;
    SRAM_ADDR = 18'd0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = data[15:0];
    case (state)
      IDLE: begin
        ready_c = ~req;
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        SRAM_ADDR = {word, 1'b0};
        dq_oe     = op_wr;
        // WE drops back high on the last cycle so the address is stable across the write pulse.
        SRAM_WE_N = ~(op_wr & ~last);
        if (last) begin
          cap_lo    = ~op_wr;
          cnt_nxt   = 4'd0;
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        SRAM_ADDR = {word, 1'b1};
        dq_oe     = op_wr;
        dq_out    = data[31:16];
        SRAM_WE_N = ~(op_wr & ~last);
        if (last) begin
          cap_hi    = ~op_wr;
          cnt_nxt   = 4'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        ready_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign SRAM_DQ       = dq_oe ? dq_out : 16'bz;
  assign bus.ready     = ready_c;
  assign bus.read_data = rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request latch and read assembly; a simultaneous rd/wr is taken as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr   <= 1'b0;
      word    <= 17'd0;
      data    <= 32'd0;
      rd_data <= 32'd0;
    end else begin
      if (accept) begin
        op_wr <= bus.wr_en;
        word  <= word_in;
        data  <= bus.write_data;
      end
      if (cap_lo) rd_data[15:0]  <= SRAM_DQ;
      if (cap_hi) rd_data[31:16] <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller with a behavioural SRAM and word-level memory model.
module tb_sram_controller;
  localparam int          A    = 2;
  localparam int unsigned BASE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus ();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  // Behavioural asynchronous SRAM: drives the bus only when the bench knows a load is in flight.
  logic        tb_drv;
  logic [15:0] sram_mem [0:262143];
  assign sram_dq = tb_drv ? sram_mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

  typedef struct {
    bit          wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } txn_t;

  txn_t                      q[$];
  logic [31:0]               ref_mem [int unsigned];
  logic [31:0]               last_read;
  logic [31:0]               waddrs[$];
  int                        checks = 0;
  int                        errors = 0;
  bit                        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off[18:2];
  endfunction

  // Monitor: everything sampled on the falling edge, half a cycle from the DUT's updates.
  int stall_cnt = 0;
  int we_cnt    = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      logic req;
      txn_t t;
      req = bus.wr_en | bus.rd_en;
      if (!sram_we_n) begin
        we_cnt++;
        if (q.size() == 0) check("we_without_txn", 32'(sram_we_n), 32'd1);
        else begin
          t = q[0];
          check("we_on_store", 32'(t.wr), 32'd1);
          check("we_dq", 32'(sram_dq), sram_addr[0] ? 32'(t.wdata[31:16]) : 32'(t.wdata[15:0]));
        end
      end
      if (req && sram_addr != 18'd0 && q.size() > 0)
        check("sram_word", 32'(sram_addr[17:1]), 32'(q[0].word));
      if (req && !bus.ready) stall_cnt++;
      if (req && bus.ready) begin
        if (q.size() == 0) check("unexpected_done", 32'(bus.ready), 32'd0);
        else begin
          t = q.pop_front();
          check("stall_cycles", 32'(stall_cnt), 32'(2 * A + 1));
          check("we_low_cycles", 32'(we_cnt), t.wr ? 32'(2 * (A - 1)) : 32'd0);
          check(t.wr ? "read_data_kept" : "read_data", bus.read_data, t.exp_rd);
        end
        stall_cnt = 0;
        we_cnt    = 0;
      end
      if (!req) begin
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_addr", 32'(sram_addr), 32'd0);
        check("idle_we_n", 32'(sram_we_n), 32'd1);
      end
    end
  end

  task automatic issue(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    bit   done;
    t.wr    = wr;
    t.word  = word_of(addr);
    t.wdata = wdata;
    if (wr) begin
      ref_mem[32'(t.word)] = wdata;
      t.exp_rd = last_read;
      waddrs.push_back(addr);
    end else begin
      t.exp_rd  = ref_mem.exists(32'(t.word)) ? ref_mem[32'(t.word)] : 32'd0;
      last_read = t.exp_rd;
    end
    q.push_back(t);
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = addr;
    bus.write_data = wdata;
    tb_drv         = ~wr;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = bus.ready;
    end
    if (!done) begin
      check("ready_timeout", 32'(bus.ready), 32'd1);
      q.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_read = 32'd0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tb_drv    = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    tb_drv = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.address = 32'd0;
    bus.write_data = 32'd0;
    last_read = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_read_data", bus.read_data, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Store then an immediately following load of the same word (back-to-back).
    issue(1'b1, 1'b0, 32'd1044, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 32'd1044, 32'd0);
    idle(3);
    // Addresses below the base wrap to the top of the SRAM.
    issue(1'b1, 1'b0, 32'd0, 32'h1234_5678);
    issue(1'b0, 1'b1, 32'd0, 32'd0);
    idle(2);
    // Both enables: store wins, read_data untouched.
    issue(1'b1, 1'b1, 32'd1048, 32'hCAFE_F00D);
    issue(1'b0, 1'b1, 32'd1048, 32'd0);
    idle(4);

    // Reset during the low half of a store abandons it.
    mon_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.address = BASE + 32'd400;
    bus.write_data = 32'h5555_AAAA;
    tb_drv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_read = 32'd0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_addr", 32'(sram_addr), 32'd0);
    check("abort_read_data", bus.read_data, 32'd0);
    mon_en = 1'b1;
    issue(1'b0, 1'b1, 32'd1044, 32'd0);

    for (int n = 0; n < 200; n++) begin
      int unsigned sel;
      logic [31:0] addr;
      sel = $urandom_range(0, 9);
      if (sel < 5 || waddrs.size() == 0) begin
        addr = ($urandom_range(0, 3) == 0) ? $urandom
                                           : BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        issue(1'b1, sel == 0, addr, $urandom);
      end else begin
        addr = (waddrs[$urandom_range(0, waddrs.size() - 1)] & ~32'd3) | 32'($urandom_range(0, 3));
        issue(1'b0, 1'b1, addr, $urandom);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle bridge between the MEM stage and the off-chip 16-bit SRAM. It turns one 32-bit load/store request from the MEM stage into two sequential 16-bit SRAM accesses, low half first. It holds `ready` low while busy; `ready` drives the pipeline freeze, so the stages upstream of MEM stall until the access completes. The block sits directly downstream of the MEM stage and owns the `SRAM_DQ`, `SRAM_ADDR` and `SRAM_WE_N` pins.

## Interface

Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `ACCESS_CYCLES`, default 2: cycles spent on each 16-bit half. Legal range is 2..15.

Ports (clock and reset first):
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: store request from MEM, level, held until `ready`.
- `rd_en` in 1: load request from MEM, level, held until `ready`.
- `address` in 32: byte address (the ALU result).
- `write_data` in 32: store data (Val_Rm).
- `read_data` out 32: load result, registered, held until the next load completes.
- `ready` out 1: high means MEM may advance. The pipeline freeze is `~ready`.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: SRAM write enable, active low.

## Operation

Request capture:
- Request = `wr_en | rd_en`. If both are asserted, the request is treated as a write.
- On acceptance the block latches: operation, `word = (address - BASE_ADDR) >> 2` truncated to 17 bits, and `write_data`.
- The subtraction is modulo 2^32. Bits [1:0] of the address are ignored.

State machine:
- **IDLE**
  - `ready = ~request` (combinational).
  - On request: latch as above, clear `cnt`, go to LOW.
- **LOW**
  - `SRAM_ADDR = {word, 1'b0}`.
  - Write: `SRAM_DQ = data[15:0]`.
  - `cnt` increments each cycle. On `cnt == ACCESS_CYCLES-1`: a read captures `SRAM_DQ` into `read_data[15:0]`; clear `cnt`; go to HIGH.
- **HIGH**
  - `SRAM_ADDR = {word, 1'b1}`.
  - Write: `SRAM_DQ = data[31:16]`.
  - On the last count: a read captures `SRAM_DQ` into `read_data[31:16]`; go to DONE.
- **DONE**
  - `ready = 1` regardless of request; the same instruction is still presented this cycle.
  - Always go to IDLE next cycle. No new access starts from DONE.

Bus and output rules:
- `SRAM_WE_N` is 0 only in LOW/HIGH, for a write, with `cnt < ACCESS_CYCLES-1`. It is 1 on the last cycle of each half, so the address never changes while WE is low.
- `SRAM_DQ` is driven only in LOW/HIGH during a write. In all other cases it is high-Z.
- `SRAM_ADDR` is 0 in IDLE and DONE.
- All pin outputs decode only from registered state. They do not depend combinationally on the request inputs.
- `read_data` is updated only by reads; writes leave it unchanged. Low and high halves update in separate cycles, so `read_data` is valid only from DONE onward.

Reset:
- Any cycle with `rst` high: state becomes IDLE, `cnt=0`, `read_data=0`, latched regs cleared.
- After the reset edge: `SRAM_WE_N=1`, `SRAM_DQ` is Z, `SRAM_ADDR=0`.
- A reset during LOW or HIGH abandons the access. A partially written word may remain in the SRAM; this is allowed.

## Timing

Let the request first be seen in IDLE at cycle t, and let A = `ACCESS_CYCLES`.
- LOW occupies t+1 .. t+A.
- HIGH occupies t+A+1 .. t+2A.
- DONE is at t+2A+1.
- `ready` is 0 from t through t+2A and 1 at t+2A+1.
- With default A=2: stall is 5 cycles, `ready` rises at t+5.
- Back-to-back requests: DONE at t+5, IDLE at t+6. If a new request is present at t+6, `ready` is 0 again at t+6.
- No request: the block sits in IDLE with `ready=1`.
- Read data is valid at `read_data` from t+2A+1 and stable until the next read's LOW capture.

## Test plan

- **Store:** `wr_en=1`, `address=1044`, `write_data=0xDEADBEEF`.
  - `SRAM_ADDR=10` with DQ=0xBEEF and `SRAM_WE_N=0` at t+1.
  - `SRAM_ADDR=11` with DQ=0xDEAD and WE_N=0 at t+3.
  - WE_N=1 at t+2 and t+4; `ready=1` only at t+5.
- **Load after store:** SRAM model returns the stored halves; `rd_en=1`, `address=1044`.
  - `read_data=0xDEADBEEF` at t+5.
  - `SRAM_WE_N` stays 1 throughout and `SRAM_DQ` is never driven.
- **Back-to-back:** store then immediate load, requests held per the `ready` protocol.
  - Exactly two 6-cycle transactions; `ready` pattern 000001000001.
- **Wrap:** `rd_en=1`, `address=0`.
  - `SRAM_ADDR=0x3FE00`, then `0x3FE01`.
- **Reset mid-write:** assert `rst` at t+1 of a store.
  - Next cycle: IDLE, `SRAM_WE_N=1`, DQ Z, `ready=1`, `read_data=0`.
  - A subsequent request completes normally.
- **Idle/conflict:** no request gives `ready=1` and `SRAM_ADDR=0` indefinitely. `rd_en=wr_en=1` performs a write and `read_data` is unchanged.
